sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 0: expected value at sysid word 0 (system ID).
REQ-002 SHALL have parameter EXPECTED_TS, default 1537796191 (0x5BA8E85F): expected value at sysid word 1 (timestamp).
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum consecutive waitrequest cycles per read attempt, range 1..65535.
REQ-004 SHALL have parameter RETRIES, default 2: extra attempts per word after a timeout, range 0..7.
REQ-005 SHALL have port clock  in  1: the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset  in  1: reset, synchronous and active-high.
REQ-007 SHALL have port start  in  1: single-cycle request to run one check.
REQ-008 SHALL have port busy  out  1: check in progress.
REQ-009 SHALL have port done  out  1: one-cycle pulse when a check completes.
REQ-010 SHALL have ports id_ok, ts_ok, timeout  out  1 each: result flags of the last check.
REQ-011 SHALL have ports id_value, ts_value  out  32 each: words captured in the last check.
REQ-012 SHALL have port m_address  out  1: Avalon-MM master word address to the sysid slave.
REQ-013 SHALL have port m_read  out  1: Avalon-MM read strobe.
REQ-014 SHALL have port m_readdata  in  32: Avalon-MM read data.
REQ-015 SHALL have port m_waitrequest  in  1: Avalon-MM wait request; tie low for a zero-wait slave.

Function
REQ-016 SHALL implement states IDLE, RD_ID, RD_TS, BACKOFF, FINISH.
REQ-017 IDLE: start=1 SHALL move to RD_ID, set busy=1, clear id_ok/ts_ok/timeout, zero the wait and retry counters; id_value/ts_value keep old values until overwritten.
REQ-018 start while busy=1 SHALL be ignored with no queuing.
REQ-019 RD_ID SHALL drive m_read=1, m_address=0; RD_TS SHALL drive m_read=1, m_address=1; all other states SHALL drive m_read=0, m_address=0.
REQ-020 m_read and m_address SHALL stay constant while m_waitrequest=1.
REQ-021 A read completes on the edge where m_read=1 and m_waitrequest=0; m_readdata SHALL be captured on that edge (id_value in RD_ID, ts_value in RD_TS).
REQ-022 RD_ID completion SHALL go to RD_TS and reset the wait and retry counters; RD_TS completion SHALL go to FINISH.
REQ-023 Wait counter (16 bit) SHALL increment each cycle m_read=1 and m_waitrequest=1; on reaching TIMEOUT SHALL go to BACKOFF, increment the retry counter, zero the wait counter.
REQ-024 BACKOFF SHALL last exactly one cycle with m_read=0, then re-enter the word state that timed out.
REQ-025 A timeout with retry counter already equal to RETRIES SHALL go to FINISH with timeout=1, id_ok=0, ts_ok=0.
REQ-026 FINISH (one cycle) SHALL register id_ok=(id_value==EXPECTED_ID), ts_ok=(ts_value==EXPECTED_TS) unless timing out, pulse done=1 on the following cycle with busy=0, and return to IDLE.
REQ-027 Zero-wait latency: start sampled at edge N -> reads at edges N+1, N+2 -> done=1 and flags valid in the cycle after edge N+3.
REQ-028 Flags and captured values SHALL hold until the next accepted start.
REQ-029 start coincident with the done cycle SHALL be accepted (state is IDLE).

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, busy=0, done=0, m_read=0, m_address=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, counters=0, overriding any in-flight read and any coincident start.
REQ-031 Deassertion of reset SHALL need no extra cycles; start is accepted on the first edge with reset=0.

Verification
REQ-032 Zero-wait slave returning 0 at word 0 and 1537796191 at word 1, start pulse -> done at N+4, id_ok=1, ts_ok=1, timeout=0, ts_value=0x5BA8E85F.
REQ-033 Slave returns 0x12345678 at word 1 -> done, id_ok=1, ts_ok=0, ts_value=0x12345678.
REQ-034 waitrequest held 3 cycles on each read -> m_read/m_address stable throughout, done at N+10, both ok flags 1.
REQ-035 TIMEOUT=4, RETRIES=1, waitrequest stuck high -> m_read pattern 4 high, 1 low, 4 high on word 0 only, then done with timeout=1, id_ok=0, ts_ok=0.
REQ-036 reset asserted in RD_TS with waitrequest high -> next cycle m_read=0, busy=0, all flags and values 0; new start then completes normally.
REQ-037 Second start pulse during busy -> ignored, exactly one done pulse observed.

Source files
------------

// File: rtl/sysid_checker.sv
// Reads the two sysid words over an Avalon-MM master port, compares them with the
// expected system ID and timestamp, and reports the result with per-word timeout/retry.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1537796191,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned RETRIES     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    RD_TS   = 3'd2,
    BACKOFF = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(RETRIES);

  state_t      state_reg, state_next;
  logic [15:0] wait_reg;
  logic [2:0]  retry_reg;
  logic        word_reg;   // word that last timed out: 0 = ID, 1 = timestamp
  logic        done_reg;
  logic        id_ok_reg, ts_ok_reg, timeout_reg;
  logic [31:0] id_value_reg, ts_value_reg;

  logic reading, accept, complete, expire, give_up;

  always_comb begin
    reading  = (state_reg == RD_ID) || (state_reg == RD_TS);
    accept   = (state_reg == IDLE) && start;
    complete = reading && !m_waitrequest;
    expire   = reading && m_waitrequest && (wait_reg == WAIT_LAST);
    give_up  = expire && (retry_reg == RETRY_MAX);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RD_ID;
      end
      RD_ID: begin
        if (complete)     state_next = RD_TS;
        else if (give_up) state_next = FINISH;
        else if (expire)  state_next = BACKOFF;
      end
      RD_TS: begin
        if (complete)     state_next = FINISH;
        else if (give_up) state_next = FINISH;
        else if (expire)  state_next = BACKOFF;
      end
      BACKOFF: begin
        state_next = word_reg ? RD_TS : RD_ID;
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_reg     <= 16'd0;
      retry_reg    <= 3'd0;
      word_reg     <= 1'b0;
      done_reg     <= 1'b0;
      id_ok_reg    <= 1'b0;
      ts_ok_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
      id_value_reg <= 32'd0;
      ts_value_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == FINISH);

      if (accept) begin
        id_ok_reg   <= 1'b0;
        ts_ok_reg   <= 1'b0;
        timeout_reg <= 1'b0;
        wait_reg    <= 16'd0;
        retry_reg   <= 3'd0;
      end

      if (reading) begin
        if (complete) begin
          wait_reg <= 16'd0;
          if (state_reg == RD_ID) begin
            id_value_reg <= m_readdata;
            retry_reg    <= 3'd0;
          end else begin
            ts_value_reg <= m_readdata;
          end
        end else if (expire) begin
          wait_reg  <= 16'd0;
          retry_reg <= retry_reg + 3'd1;
          word_reg  <= (state_reg == RD_TS);
          if (give_up) timeout_reg <= 1'b1;
        end else begin
          wait_reg <= wait_reg + 16'd1;
        end
      end

      // A timed-out check leaves both ok flags cleared from the start cycle.
      if ((state_reg == FINISH) && !timeout_reg) begin
        id_ok_reg <= (id_value_reg == EXPECTED_ID);
        ts_ok_reg <= (ts_value_reg == EXPECTED_TS);
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign id_ok     = id_ok_reg;
  assign ts_ok     = ts_ok_reg;
  assign timeout   = timeout_reg;
  assign id_value  = id_value_reg;
  assign ts_value  = ts_value_reg;
  assign m_read    = reading;
  assign m_address = (state_reg == RD_TS);

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: table of slave responses plus hand-written
// sequences for reset abort, ignored start, back-to-back start and timeout/retry.
module tb_sysid_checker;

  logic        clock = 1'b0;
  logic        reset, start;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic        m_address, m_read;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  logic        start2;
  logic        busy2, done2, id_ok2, ts_ok2, timeout2;
  logic [31:0] id_value2, ts_value2;
  logic        m_address2, m_read2;
  logic [31:0] m_readdata2;
  logic        m_waitrequest2;

  // Slave model for the default-parameter instance
  logic [31:0] id_word, ts_word;
  int          wait_len;
  logic        stuck_ts;
  int          wcnt;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int done_cnt = 0;
  logic hold_pending;
  logic hold_addr;

  always #5 clock = ~clock;

  sysid_checker dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value),
    .m_address(m_address), .m_read(m_read),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
  );

  sysid_checker #(.TIMEOUT(4), .RETRIES(1)) dut_to (
    .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .id_ok(id_ok2), .ts_ok(ts_ok2), .timeout(timeout2),
    .id_value(id_value2), .ts_value(ts_value2),
    .m_address(m_address2), .m_read(m_read2),
    .m_readdata(m_readdata2), .m_waitrequest(m_waitrequest2)
  );

  assign m_readdata     = m_address ? ts_word : id_word;
  assign m_waitrequest  = m_read && ((stuck_ts && m_address) || (wcnt < wait_len));
  assign m_readdata2    = 32'd0;
  assign m_waitrequest2 = 1'b1;

  always @(posedge clock) begin
    if (m_read && m_waitrequest) wcnt <= wcnt + 1;
    else                         wcnt <= 0;
    if (done) done_cnt <= done_cnt + 1;
    hold_pending <= m_read && m_waitrequest && !reset;
    hold_addr    <= m_address;
  end

  // Master signals must not move while the slave is stalling
  always @(negedge clock) begin
    if (hold_pending && (!m_read || (m_address != hold_addr))) viol <= viol + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulse start and return the number of edges after the start edge until done is seen.
  task automatic pulse_and_wait(output int lat);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          wait_len;
    logic        exp_id_ok;
    logic        exp_ts_ok;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int dc0;
    logic [9:0] pattern;
    logic addr_seen;

    vecs[0] = '{32'h0000_0000, 32'h5BA8_E85F, 0, 1'b1, 1'b1, 3};
    vecs[1] = '{32'h0000_0000, 32'h1234_5678, 0, 1'b1, 1'b0, 3};
    vecs[2] = '{32'h0000_0000, 32'h5BA8_E85F, 3, 1'b1, 1'b1, 9};
    vecs[3] = '{32'h0000_0001, 32'h5BA8_E85F, 0, 1'b0, 1'b1, 3};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0, 1'b0, 5};
    vecs[5] = '{32'h0000_0000, 32'h5BA8_E85F, 2, 1'b1, 1'b1, 7};

    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    id_word = 32'd0; ts_word = 32'd0; wait_len = 0; stuck_ts = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_m_read", 32'(m_read), 32'd0);
    chk("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      id_word  = vecs[i].id_word;
      ts_word  = vecs[i].ts_word;
      wait_len = vecs[i].wait_len;
      pulse_and_wait(lat);
      chk("latency", 32'(lat), 32'(vecs[i].exp_lat));
      chk("id_ok", 32'(id_ok), 32'(vecs[i].exp_id_ok));
      chk("ts_ok", 32'(ts_ok), 32'(vecs[i].exp_ts_ok));
      chk("timeout", 32'(timeout), 32'd0);
      chk("id_value", id_value, vecs[i].id_word);
      chk("ts_value", ts_value, vecs[i].ts_word);
      chk("busy_at_done", 32'(busy), 32'd0);
      @(posedge clock);
      #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("flags_hold", {30'd0, id_ok, ts_ok}, {30'd0, vecs[i].exp_id_ok, vecs[i].exp_ts_ok});
      $display("vector %0d: id=0x%08h ts=0x%08h wait=%0d lat=%0d id_ok=%0b ts_ok=%0b",
               i, vecs[i].id_word, vecs[i].ts_word, vecs[i].wait_len, lat, id_ok, ts_ok);
    end

    // Reset while the timestamp read is stalled
    id_word = 32'h0000_ABCD; ts_word = 32'h5BA8_E85F; wait_len = 0; stuck_ts = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("in_rd_ts", {30'd0, m_read, m_address}, 32'd3);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_m_read", 32'(m_read), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    chk("abort_id_value", id_value, 32'd0);
    chk("abort_ts_value", ts_value, 32'd0);
    stuck_ts = 1'b0; id_word = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("start_after_reset", 32'(busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clock);
      #1;
      if (done) begin lat = k; break; end
    end
    chk("post_reset_latency", 32'(lat), 32'd3);
    chk("post_reset_ok", {30'd0, id_ok, ts_ok}, 32'd3);
    $display("reset abort: lat=%0d id_ok=%0b ts_ok=%0b", lat, id_ok, ts_ok);

    // Start accepted in the done cycle
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("start_on_done", 32'(busy), 32'd1);
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clock);
      #1;
      if (done) begin lat = k; break; end
    end
    chk("b2b_latency", 32'(lat), 32'd3);
    $display("start on done cycle: lat=%0d", lat);

    // Second start while busy is ignored
    wait_len = 2;
    @(posedge clock);
    #1;
    dc0 = done_cnt;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (25) @(posedge clock);
    #1;
    chk("single_done", 32'(done_cnt - dc0), 32'd1);
    chk("idle_after_ignored", 32'(busy), 32'd0);
    $display("ignored start: done pulses=%0d", done_cnt - dc0);

    chk("hold_violations", 32'(viol), 32'd0);

    // Timeout/retry on the TIMEOUT=4, RETRIES=1 instance with a stuck slave
    pattern = '0;
    addr_seen = 1'b0;
    @(negedge clock);
    start2 = 1'b1;
    @(posedge clock);
    #1;
    start2 = 1'b0;
    pattern[0] = m_read2;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock);
      #1;
      pattern[k] = m_read2;
      addr_seen = addr_seen | m_address2;
    end
    lat = -1;
    for (int k = 10; k <= 40; k++) begin
      @(posedge clock);
      #1;
      addr_seen = addr_seen | m_address2;
      if (done2) begin lat = k; break; end
    end
    chk("to_read_pattern", 32'(pattern), 32'b01_1110_1111);
    chk("to_address", 32'(addr_seen), 32'd0);
    chk("to_latency", 32'(lat), 32'd10);
    chk("to_flags", {29'd0, id_ok2, ts_ok2, timeout2}, 32'd1);
    chk("to_busy", 32'(busy2), 32'd0);
    $display("timeout: pattern=%b lat=%0d timeout=%0b", pattern, lat, timeout2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
